// File: rtl/store_buffer_if.sv
// store_buffer_if: store, load-check and write-bus signals of the store buffer.
// The master side is the pipeline plus the bus; the slave side is the buffer.
interface store_buffer_if;
  // store request from the alignment stage
  logic        we;
  logic [31:0] Adr;
  logic [31:0] Din;
  logic [3:0]  ByteEN;
  logic        stall;

  // load hazard check
  logic        ld_en;
  logic [31:0] ld_adr;
  logic        ld_stall;

  // write beat to the bus
  logic [31:0] bus_adr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_req;
  logic        bus_ack;

  modport master (
    output we, Adr, Din, ByteEN, ld_en, ld_adr, bus_ack,
    input  stall, ld_stall, bus_adr, bus_wdata, bus_be, bus_req
  );

  modport slave (
    input  we, Adr, Din, ByteEN, ld_en, ld_adr, bus_ack,
    output stall, ld_stall, bus_adr, bus_wdata, bus_be, bus_req
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: 4-entry store FIFO draining one write beat at a time to the bus.
// Loads that hit a pending (or in-flight) word are held with ld_stall.
// Optional feature: define STOREBUF_MERGE_EN to merge a store into the youngest
// entry when it targets the same word (never into a beat already on the bus).
module store_buffer (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned AW    = 30;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  state_t           state_d;

  logic [AW-1:0]    ent_adr  [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [BW-1:0]    ent_be   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             be_any_c;
  logic             full_c;
  logic             merge_hit_c;
  logic             push_c;
  logic             pop_c;
  logic             launch_c;
  logic             ld_hit_c;
  logic [AW-1:0]    st_line_c;
  logic [AW-1:0]    ld_line_c;
  logic [DW-1:0]    launch_data_c;
  logic [BW-1:0]    launch_be_c;
  logic             unused_c;

  assign be_any_c  = (sb.ByteEN != '0);
  assign full_c    = (count == CNT_W'(DEPTH));
  assign st_line_c = sb.Adr[31:2];
  assign ld_line_c = sb.ld_adr[31:2];

  // byte offsets never reach the buffer; entries are word granular
  assign unused_c = ^{sb.Adr[1:0], sb.ld_adr[1:0]};

`ifdef STOREBUF_MERGE_EN
  logic [PTR_W-1:0] tail_m1_c;
  logic [DW-1:0]    merged_data_c;
  logic [BW-1:0]    merged_be_c;

  assign tail_m1_c = PTR_W'(tail - PTR_W'(1));

  // youngest entry matches the store word and is not the beat on the bus
  assign merge_hit_c = sb.we && (count != '0)
                    && (ent_adr[tail_m1_c] == st_line_c)
                    && !((state == REQ) && (count == CNT_W'(1)));

  // byte-lane overlay of the new store onto the youngest entry
  always_comb begin
    merged_data_c = ent_data[tail_m1_c];
    for (int unsigned i = 0; i < BW; i++) begin
      if (sb.ByteEN[i]) begin
        merged_data_c[8*i +: 8] = sb.Din[8*i +: 8];
      end
    end
  end

  assign merged_be_c = ent_be[tail_m1_c] | sb.ByteEN;
`else
  assign merge_hit_c = 1'b0;
`endif

  // a full buffer holds the store unless it folds into an existing entry
  assign sb.stall = sb.we && be_any_c && full_c && !merge_hit_c;
  assign push_c   = sb.we && be_any_c && !full_c && !merge_hit_c;

  // bus FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // bus FSM next state: launch the head beat, pop it on acknowledge
  always_comb begin
    state_d  = state;
    launch_c = 1'b0;
    pop_c    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_d  = REQ;
          launch_c = 1'b1;
        end
      end
      REQ: begin
        if (sb.bus_ack) begin
          state_d = IDLE;
          pop_c   = 1'b1;
        end
      end
    endcase
  end

  // head payload for a launching beat, including a merge landing on it this cycle
  always_comb begin
    launch_data_c = ent_data[head];
    launch_be_c   = ent_be[head];
`ifdef STOREBUF_MERGE_EN
    if (merge_hit_c && (tail_m1_c == head)) begin
      launch_data_c = merged_data_c;
      launch_be_c   = merged_be_c;
    end
`endif
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_c) begin
        tail <= PTR_W'(tail + PTR_W'(1));
      end
      if (pop_c) begin
        head <= PTR_W'(head + PTR_W'(1));
      end
      if (push_c && !pop_c) begin
        count <= CNT_W'(count + CNT_W'(1));
      end else if (pop_c && !push_c) begin
        count <= CNT_W'(count - CNT_W'(1));
      end
    end
  end

  // entry storage; contents are only meaningful while counted as valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      ent_adr[tail]  <= st_line_c;
      ent_data[tail] <= sb.Din;
      ent_be[tail]   <= sb.ByteEN;
    end
`ifdef STOREBUF_MERGE_EN
    if (merge_hit_c) begin
      ent_data[tail_m1_c] <= merged_data_c;
      ent_be[tail_m1_c]   <= merged_be_c;
    end
`endif
  end

  // registered write beat, held stable while the request is outstanding
  always_ff @(posedge clk) begin
    if (!reset) begin
      sb.bus_req   <= 1'b0;
      sb.bus_adr   <= '0;
      sb.bus_wdata <= '0;
      sb.bus_be    <= '0;
    end else if (launch_c) begin
      sb.bus_req   <= 1'b1;
      sb.bus_adr   <= {ent_adr[head], 2'b00};
      sb.bus_wdata <= launch_data_c;
      sb.bus_be    <= launch_be_c;
    end else if (pop_c) begin
      sb.bus_req   <= 1'b0;
    end
  end

  // load hazard: any valid entry, in-flight head included, on the load's word
  always_comb begin
    ld_hit_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(i) - head)) < count) && (ent_adr[i] == ld_line_c)) begin
        ld_hit_c = 1'b1;
      end
    end
  end

  assign sb.ld_stall = sb.ld_en && ld_hit_c;

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset sampled on clk rising edge.
REQ-003 SHALL have port we, input, 1, store request valid from the store-alignment stage this cycle.
REQ-004 SHALL have port Adr, input, 32, byte address of the store.
REQ-005 SHALL have port Din, input, 32, lane-aligned store data.
REQ-006 SHALL have port ByteEN, input, 4, byte-lane enables; bit i covers Din[8i+7:8i].
REQ-007 SHALL have port stall, output, 1, pipeline hold: store not accepted this cycle.
REQ-008 SHALL have port ld_en, input, 1, load access in MEM this cycle.
REQ-009 SHALL have port ld_adr, input, 32, load byte address.
REQ-010 SHALL have port ld_stall, output, 1, load must wait: a matching store is pending.
REQ-011 SHALL have ports bus_adr (output, 32), bus_wdata (output, 32) and bus_be (output, 4), the write beat to the bus; bus_adr[1:0] SHALL be 2'b00.
REQ-012 SHALL have port bus_req, output, 1, registered write request.
REQ-013 SHALL have port bus_ack, input, 1, bus accepts the beat this cycle.

Function
REQ-014 SHALL hold a 4-entry FIFO; each entry is {Adr[31:2], data[31:0], be[3:0]}, with head, tail and count (0..4) registers.
REQ-015 Push: we=1, ByteEN!=0, count<4, no merge -> entry written at tail, count+1 at the next edge.
REQ-016 we=1 with ByteEN=0 SHALL be dropped without stall.
REQ-017 stall = we & (ByteEN!=0) & (count==4) & ~merge_hit, combinational; a stalled store SHALL NOT be written; stall SHALL NOT depend on same-cycle bus_ack.
REQ-018 Bus FSM states: IDLE, REQ; reset state IDLE.
REQ-019 IDLE -> REQ when count>0; bus_req, bus_adr, bus_wdata and bus_be are registered from the head entry on that edge.
REQ-020 In REQ, bus_req=1 and bus outputs SHALL stay stable until bus_ack=1.
REQ-021 REQ with bus_ack=1 -> IDLE; the head is popped and count decremented on that edge; bus_req=0 for at least one cycle between beats.
REQ-022 Push and pop on the same edge SHALL leave count unchanged; pointers wrap modulo 4.
REQ-023 ld_stall = ld_en & (some valid entry, including the in-flight head, has address equal to ld_adr[31:2]), combinational.
REQ-024 Minimum store-to-bus latency SHALL be: push at edge N, bus_req=1 after edge N+1.

Reset
REQ-025 reset=0 at an edge SHALL set count=0, head=tail=0, FSM=IDLE, bus_req=0, bus_adr=0, bus_wdata=0 and bus_be=0.
REQ-026 Reset mid-transaction SHALL discard all entries, including the in-flight beat, with no further bus_req; a same-cycle bus_ack is ignored.
REQ-027 After reset, stall=0 and ld_stall=0 until a new store is accepted.

Configuration
REQ-028 Macro STOREBUF_MERGE_EN SHALL gate write merging.
REQ-029 With STOREBUF_MERGE_EN: merge_hit = we & count>0 & (tail-1 entry address == Adr[31:2]) & ~(FSM==REQ & count==1).
REQ-030 On merge_hit, byte lanes enabled in ByteEN SHALL overwrite that entry's data, entry be |= ByteEN, count is unchanged, and no stall occurs even when full.
REQ-031 Without STOREBUF_MERGE_EN: merge_hit SHALL be constant 0 and every store occupies its own entry.

Verification
REQ-032 Reset, then we=1, Adr=0x0000_1003, Din=0xAB00_0000, ByteEN=4'b1000, bus_ack=0 -> after 2 edges bus_req=1, bus_adr=0x0000_1000, bus_wdata=0xAB00_0000, bus_be=4'b1000, held stable until bus_ack.
REQ-033 Four stores to 0x10, 0x20, 0x30, 0x40 with bus_ack=0, then a fifth to 0x50 -> stall=1 on the fifth; one bus_ack -> stall=0 next cycle, 0x50 accepted, and the FIFO order 0x20, 0x30, 0x40, 0x50 is preserved.
REQ-034 Store word 0x11223344 to 0x100 pending, then ld_en=1 with ld_adr=0x102 -> ld_stall=1; after ack and pop -> ld_stall=0; ld_adr=0x104 -> ld_stall=0 throughout.
REQ-035 With STOREBUF_MERGE_EN, head busy: stores sb 0xAA to 0x201, then sb 0xBB to 0x203 -> one entry with be=4'b1010 and data=0xBB00_AA00; without the macro -> two entries and two beats.
REQ-036 Assert reset=0 while in REQ with count=3 and bus_ack=1 in the same cycle -> next cycle bus_req=0 and count=0, and no beat is issued afterwards.
